// File: rtl/stream_gen_ctrl_if.sv
// stream_gen_ctrl_if: control/handshake bundle between stream_gen_ctrl and its FIFO and counter neighbours
interface stream_gen_ctrl_if;
    logic        start;
    logic        stop;
    logic        fifo_almost_full;
    logic        fifo_full;
    logic        counter_en;
    logic        fifo_wr_en;
    logic        pkt_end;
    logic        busy;
    logic [15:0] pkt_count;
    logic        ovf_err;
    modport master (
        input  start, stop, fifo_almost_full, fifo_full,
        output counter_en, fifo_wr_en, pkt_end, busy, pkt_count, ovf_err
    );
    modport slave (
        output start, stop, fifo_almost_full, fifo_full,
        input  counter_en, fifo_wr_en, pkt_end, busy, pkt_count, ovf_err
    );
endinterface

// File: rtl/stream_gen_ctrl.sv
// stream_gen_ctrl: packetised write sequencer feeding a counter generator into a FIFO.
// Optional sticky overflow detector enabled by macro STREAM_GEN_OVF_CHECK_EN.
module stream_gen_ctrl #(
    parameter int PKT_LEN    = 256,
    parameter int GAP_CYCLES = 4,
    parameter int NUM_PKTS   = 0
) (
    input logic               clk,
    input logic               reset_,
    stream_gen_ctrl_if.master sg
);
    typedef enum logic [1:0] {IDLE, STREAM, GAP, DONE} state_t;
    state_t      state, state_nxt;
    logic [15:0] word_cnt, word_nxt, pkt_cnt, pkt_nxt;
    logic [7:0]  gap_cnt, gap_nxt;
    logic        stop_pend, stop_nxt, wr, last, busy_q;
    always_comb begin
        state_nxt = state;
        word_nxt  = word_cnt;
        pkt_nxt   = pkt_cnt;
        gap_nxt   = gap_cnt;
        stop_nxt  = stop_pend;
        wr        = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: if (sg.start && !sg.stop) begin
                state_nxt = STREAM;
                word_nxt  = 16'd0;
                pkt_nxt   = 16'd0;
            end
            STREAM: begin
                stop_nxt = stop_pend || sg.stop;
                wr       = !sg.fifo_almost_full;
                if (wr) begin
                    word_nxt = word_cnt + 16'd1;
                    if (word_cnt == 16'(PKT_LEN - 1)) begin
                        last     = 1'b1;
                        word_nxt = 16'd0;
                        pkt_nxt  = pkt_cnt + 16'd1;
                        gap_nxt  = 8'd0;
                        // a stop arriving on the final word still ends the run here
                        if (stop_nxt || (NUM_PKTS != 0 && pkt_nxt == 16'(NUM_PKTS)))
                            state_nxt = DONE;
                        else if (GAP_CYCLES > 0)
                            state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                stop_nxt = stop_pend || sg.stop;
                gap_nxt  = gap_cnt + 8'd1;
                if (gap_cnt == 8'(GAP_CYCLES - 1))
                    state_nxt = stop_nxt ? DONE : STREAM;
            end
            DONE: begin
                state_nxt = IDLE;
                stop_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= IDLE;
            word_cnt  <= 16'd0;
            pkt_cnt   <= 16'd0;
            gap_cnt   <= 8'd0;
            stop_pend <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            word_cnt  <= word_nxt;
            pkt_cnt   <= pkt_nxt;
            gap_cnt   <= gap_nxt;
            stop_pend <= stop_nxt;
            busy_q    <= state_nxt != IDLE;
        end
    end
    assign sg.counter_en = wr;
    assign sg.fifo_wr_en = wr;
    assign sg.pkt_end    = last;
    assign sg.busy       = busy_q;
    assign sg.pkt_count  = pkt_cnt;
`ifdef STREAM_GEN_OVF_CHECK_EN
    logic ovf;
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)
            ovf <= 1'b0;
        else if (wr && sg.fifo_full)
            ovf <= 1'b1;
    end
    assign sg.ovf_err = ovf;
`else
    assign sg.ovf_err = 1'b0;
`endif
endmodule

// File: tb/tb_stream_gen_ctrl.sv
// tb_stream_gen_ctrl: directed scenarios on three configurations plus a randomized run
// checked against a behavioural packet model.
module tb_stream_gen_ctrl;
    localparam int PB_LEN = 8;
    localparam int PB_GAP = 3;
`ifdef STREAM_GEN_OVF_CHECK_EN
    localparam bit OVF_EXP = 1'b1;
`else
    localparam bit OVF_EXP = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset_ = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   gen_b = 0;
    bit   m_run, m_done, m_stop;
    int   m_gap, m_word, m_pk;

    stream_gen_ctrl_if ia();
    stream_gen_ctrl_if ib();
    stream_gen_ctrl_if ic();

    stream_gen_ctrl #(.PKT_LEN(4), .GAP_CYCLES(2), .NUM_PKTS(2)) u_a (.clk(clk), .reset_(reset_), .sg(ia));
    stream_gen_ctrl #(.PKT_LEN(PB_LEN), .GAP_CYCLES(PB_GAP), .NUM_PKTS(0)) u_b (.clk(clk), .reset_(reset_), .sg(ib));
    stream_gen_ctrl #(.PKT_LEN(3), .GAP_CYCLES(0), .NUM_PKTS(0)) u_c (.clk(clk), .reset_(reset_), .sg(ic));

    always #5 clk = ~clk;

    // counter data generator attached to instance B
    always @(posedge clk or negedge reset_)
        if (!reset_) gen_b <= 0;
        else if (ib.counter_en) gen_b <= gen_b + 1;

    task automatic test_reset();
        reset_ = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({ia.counter_en, ia.fifo_wr_en, ia.pkt_end, ia.busy, ia.pkt_count, ia.ovf_err} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_a: got %h want 0", {ia.counter_en, ia.fifo_wr_en, ia.pkt_end, ia.busy, ia.pkt_count, ia.ovf_err});
        end
        n_chk++;
        if ({ib.counter_en, ib.fifo_wr_en, ib.pkt_end, ib.busy, ib.pkt_count, ib.ovf_err} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_b: got %h want 0", {ib.counter_en, ib.fifo_wr_en, ib.pkt_end, ib.busy, ib.pkt_count, ib.ovf_err});
        end
        n_chk++;
        if ({ic.counter_en, ic.fifo_wr_en, ic.pkt_end, ic.busy, ic.pkt_count, ic.ovf_err} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_c: got %h want 0", {ic.counter_en, ic.fifo_wr_en, ic.pkt_end, ic.busy, ic.pkt_count, ic.ovf_err});
        end
        @(negedge clk) reset_ = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_two_packets();
        ia.start = 1'b1;
        #1;
        n_chk++;
        if (ia.fifo_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_write: got %b want 0", ia.fifo_wr_en);
        end
        @(posedge clk); #1;
        ia.start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            logic [3:0] exp_v, got_v;
            bit w;
            w = (i < 4) || (i >= 6 && i < 10);
            exp_v = {w, w, (i == 3 || i == 9), (i <= 10)};
            #1;
            got_v = {ia.counter_en, ia.fifo_wr_en, ia.pkt_end, ia.busy};
            n_chk++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL two_pkts cyc %0d: got ce/wr/end/busy=%b want %b", i, got_v, exp_v);
            end
            @(posedge clk); #1;
        end
        n_chk++;
        if (ia.pkt_count !== 16'd2) begin
            n_fail++;
            $display("FAIL two_pkts_count: got %0d want 2", ia.pkt_count);
        end
    endtask

    task automatic test_idle_start_stop();
        ia.start = 1'b1;
        ia.stop  = 1'b1;
        @(posedge clk); #1;
        ia.start = 1'b0;
        ia.stop  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_chk++;
            if ({ia.fifo_wr_en, ia.busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL start_stop_ignored cyc %0d: got wr/busy=%b want 00", i, {ia.fifo_wr_en, ia.busy});
            end
            @(posedge clk); #1;
        end
        ia.start = 1'b1;
        @(posedge clk); #1;
        ia.start = 1'b0;
        #1;
        n_chk++;
        if ({ia.fifo_wr_en, ia.busy, ia.pkt_count} !== {2'b11, 16'd0}) begin
            n_fail++;
            $display("FAIL start_alone: got wr/busy/cnt=%h want 30000", {ia.fifo_wr_en, ia.busy, ia.pkt_count});
        end
        repeat (7) @(posedge clk);
        #1;
        n_chk++;
        if ({ia.fifo_wr_en, ia.pkt_count} !== {1'b1, 16'd1}) begin
            n_fail++;
            $display("FAIL mid_pkt2: got wr/cnt=%h want 10001", {ia.fifo_wr_en, ia.pkt_count});
        end
        reset_ = 1'b0;
        #1;
        n_chk++;
        if ({ia.counter_en, ia.fifo_wr_en, ia.pkt_end, ia.busy, ia.pkt_count, ia.ovf_err} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_mid_pkt: got %h want 0", {ia.counter_en, ia.fifo_wr_en, ia.pkt_end, ia.busy, ia.pkt_count, ia.ovf_err});
        end
        @(negedge clk) reset_ = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({ia.fifo_wr_en, ia.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: got wr/busy=%b want 00", {ia.fifo_wr_en, ia.busy});
        end
    endtask

    task automatic test_backpressure();
        int base;
        int wq[$];
        base = gen_b;
        ib.start = 1'b1;
        @(posedge clk); #1;
        ib.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] exp_v, got_v;
            bit w;
            ib.fifo_almost_full = (i >= 3 && i < 6);
            ib.stop = (i == 11);
            w = (i < 3) || (i >= 6 && i <= 10);
            exp_v = {w, w, (i == 10), (i <= 14)};
            #1;
            got_v = {ib.counter_en, ib.fifo_wr_en, ib.pkt_end, ib.busy};
            n_chk++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL backpressure cyc %0d: got ce/wr/end/busy=%b want %b", i, got_v, exp_v);
            end
            if (ib.fifo_wr_en) wq.push_back(gen_b);
            @(posedge clk); #1;
        end
        ib.fifo_almost_full = 1'b0;
        ib.stop = 1'b0;
        n_chk++;
        if (wq.size() != PB_LEN) begin
            n_fail++;
            $display("FAIL bp_write_count: got %0d want %0d", wq.size(), PB_LEN);
        end
        for (int k = 0; k < wq.size(); k++) begin
            n_chk++;
            if (wq[k] != base + k) begin
                n_fail++;
                $display("FAIL bp_word %0d: got %0d want %0d", k, wq[k], base + k);
            end
        end
        n_chk++;
        if (ib.pkt_count !== 16'd1) begin
            n_fail++;
            $display("FAIL bp_pkt_count: got %0d want 1", ib.pkt_count);
        end
    endtask

    task automatic test_stop_graceful();
        ib.start = 1'b1;
        @(posedge clk); #1;
        ib.start = 1'b0;
        for (int i = 0; i < 56; i++) begin
            logic [3:0] exp_v, got_v;
            bit w;
            ib.stop = (i == 45);
            w = (i < 52) && (i % 11 < 8);
            exp_v = {w, w, w && (i % 11 == 7), (i <= 52)};
            #1;
            got_v = {ib.counter_en, ib.fifo_wr_en, ib.pkt_end, ib.busy};
            n_chk++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL stop_graceful cyc %0d: got ce/wr/end/busy=%b want %b", i, got_v, exp_v);
            end
            @(posedge clk); #1;
        end
        ib.stop = 1'b0;
        n_chk++;
        if (ib.pkt_count !== 16'd5) begin
            n_fail++;
            $display("FAIL stop_pkt_count: got %0d want 5", ib.pkt_count);
        end
    endtask

    task automatic test_back_to_back();
        ic.start = 1'b1;
        @(posedge clk); #1;
        ic.start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            logic [19:0] exp_v, got_v;
            bit w;
            ic.stop = (i == 12);
            w = i < 15;
            exp_v = {w, w, w && (i % 3 == 2), (i <= 15), 16'((i / 3 > 5) ? 5 : i / 3)};
            #1;
            got_v = {ic.counter_en, ic.fifo_wr_en, ic.pkt_end, ic.busy, ic.pkt_count};
            n_chk++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d: got ce/wr/end/busy/cnt=%h want %h", i, got_v, exp_v);
            end
            @(posedge clk); #1;
        end
        ic.stop = 1'b0;
    endtask

    task automatic test_overflow();
        ic.fifo_full = 1'b1;
        ic.start = 1'b1;
        @(posedge clk); #1;
        ic.start = 1'b0;
        #1;
        n_chk++;
        if ({ic.fifo_wr_en, ic.ovf_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL ovf_before_edge: got wr/ovf=%b want 10", {ic.fifo_wr_en, ic.ovf_err});
        end
        @(posedge clk); #1;
        n_chk++;
        if (ic.ovf_err !== OVF_EXP) begin
            n_fail++;
            $display("FAIL ovf_set: got %b want %b", ic.ovf_err, OVF_EXP);
        end
        ic.fifo_full = 1'b0;
        ic.stop = 1'b1;
        @(posedge clk); #1;
        ic.stop = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_chk++;
        if ({ic.busy, ic.ovf_err} !== {1'b0, OVF_EXP}) begin
            n_fail++;
            $display("FAIL ovf_sticky: got busy/ovf=%b want %b", {ic.busy, ic.ovf_err}, {1'b0, OVF_EXP});
        end
        reset_ = 1'b0;
        #1;
        n_chk++;
        if (ic.ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_reset: got %b want 0", ic.ovf_err);
        end
        @(negedge clk) reset_ = 1'b1;
        @(posedge clk); #1;
    endtask

    // packet-level model of instance B: one call per clock cycle
    task automatic model_step(input bit af, input bit st, input bit sp, output bit ew, output bit ee);
        ew = 1'b0;
        ee = 1'b0;
        if (!m_run) begin
            if (st && !sp) begin
                m_run = 1'b1;
                m_word = 0;
                m_pk = 0;
            end
        end else if (m_done) begin
            m_done = 1'b0;
            m_run = 1'b0;
            m_stop = 1'b0;
        end else if (m_gap > 0) begin
            m_stop |= sp;
            m_gap--;
            if (m_gap == 0 && m_stop) m_done = 1'b1;
        end else begin
            m_stop |= sp;
            ew = !af;
            if (ew) begin
                m_word++;
                if (m_word == PB_LEN) begin
                    ee = 1'b1;
                    m_word = 0;
                    m_pk = (m_pk + 1) % 65536;
                    if (m_stop) m_done = 1'b1;
                    else if (PB_GAP > 0) m_gap = PB_GAP;
                end
            end
        end
    endtask

    task automatic test_random();
        reset_ = 1'b0;
        m_run = 1'b0; m_done = 1'b0; m_stop = 1'b0;
        m_gap = 0; m_word = 0; m_pk = 0;
        @(negedge clk) reset_ = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 800; i++) begin
            bit af, st, sp, ew, ee, exp_b;
            logic [15:0] exp_pc;
            logic [19:0] exp_v, got_v;
            af = ($urandom % 4) == 0;
            st = ($urandom % 25) == 0;
            sp = ($urandom % 70) == 0;
            ib.fifo_almost_full = af;
            ib.start = st;
            ib.stop = sp;
            exp_b = m_run;
            exp_pc = 16'(m_pk);
            model_step(af, st, sp, ew, ee);
            exp_v = {ew, ew, ee, exp_b, exp_pc};
            #1;
            got_v = {ib.counter_en, ib.fifo_wr_en, ib.pkt_end, ib.busy, ib.pkt_count};
            n_chk++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL random cyc %0d: got ce/wr/end/busy/cnt=%h want %h", i, got_v, exp_v);
            end
            @(posedge clk); #1;
        end
        ib.fifo_almost_full = 1'b0;
        ib.start = 1'b0;
        ib.stop = 1'b0;
    endtask

    initial begin
        ia.start = 1'b0; ia.stop = 1'b0; ia.fifo_almost_full = 1'b0; ia.fifo_full = 1'b0;
        ib.start = 1'b0; ib.stop = 1'b0; ib.fifo_almost_full = 1'b0; ib.fifo_full = 1'b0;
        ic.start = 1'b0; ic.stop = 1'b0; ic.fifo_almost_full = 1'b0; ic.fifo_full = 1'b0;
        test_reset();
        test_two_packets();
        test_idle_start_stop();
        test_backpressure();
        test_stop_graceful();
        test_back_to_back();
        test_overflow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
